fetch_unit: RTL and testbench

//  Instruction fetch stage between the instruction stallmem and decode inside proc.
//  - Generates sequential PCs and issues word reads to imem.
//  - Absorbs imem's variable latency with a small prefetch FIFO.
//  - Hands {pc, instr, err} to decode over a valid/ready handshake.
//  - Accepts branch/jump redirects from execute.

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_unit_fifo.sv | 79 +++++++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions used by the instruction fetch stage:
// instruction width, reset PC, fetch FSM encodings and the FIFO entry layout.
package fetch_unit_pkg;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // 65-bit prefetch entry: pc, instruction word, fetch error flag
  typedef struct packed {
    logic [31:0]         pc;
    logic [INSTR_W-1:0]  instr;
    logic                err;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO for the fetch stage: DEPTH entries, push/pop/flush, and a
// registered head so decode sees data the cycle after it is pushed.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  fetch_entry_t                 i_data,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic                         o_valid,
  output fetch_entry_t                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     r_mem [DEPTH];
  fetch_entry_t     r_head;
  fetch_entry_t     w_head_nxt;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] w_rd_ptr_inc;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_vld;
  logic             w_push;
  logic             w_pop;

  assign w_pop        = i_pop & r_vld;
  // A push into a full FIFO is only taken when the head leaves the same cycle
  assign w_push       = i_push & ((r_count != CNT_W'(DEPTH)) | w_pop);
  assign w_rd_ptr_inc = r_rd_ptr + PTR_W'(1);
  assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_comb begin
    w_head_nxt = r_head;
    if (w_pop && (r_count > CNT_W'(1))) begin
      w_head_nxt = r_mem[w_rd_ptr_inc];
    end else if ((w_pop || !r_vld) && w_push) begin
      w_head_nxt = i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= 1'b0;
      r_head   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= 1'b0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      r_count <= w_count_nxt;
      r_vld   <= (w_count_nxt != '0);
      r_head  <= w_head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_valid = r_vld;
  assign o_head  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, single-outstanding imem
// requests, prefetch buffering and redirect handling toward decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [31:0]       imem_data_out,
  input  logic              imem_ready,
  input  logic              imem_err,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc,
  output logic              if_err,
  input  logic              id_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [31:0]       r_fetch_pc;
  logic [31:0]       w_pc_nxt;
  logic              r_en;
  logic              w_en_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_done;
  logic [31:0]       w_rpc;
  logic [31:0]       w_pc_inc;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_fifo_vld;
  fetch_entry_t      w_push_data;
  fetch_entry_t      w_head;

  assign w_rpc       = align_pc(redirect_pc);
  assign w_pc_inc    = r_fetch_pc + 32'd4;
  assign w_done      = r_en & imem_ready;
  assign w_push_data = {r_fetch_pc, imem_data_out, imem_err};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_fetch_pc;
    w_en_nxt    = r_en;
    w_addr_nxt  = r_addr;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    w_pop       = w_fifo_vld & id_ready;
    w_cnt_nxt   = w_count;
    case (r_state)
      ST_IDLE: begin
        // Any imem_ready seen here belongs to a request killed by reset
        w_pop       = 1'b0;
        w_state_nxt = ST_REQ;
        w_pc_nxt    = redirect ? w_rpc : r_fetch_pc;
        w_en_nxt    = 1'b1;
        w_addr_nxt  = w_pc_nxt[ADDR_W-1:0];
      end
      ST_REQ: begin
        if (redirect) begin
          w_flush  = 1'b1;
          w_pop    = 1'b0;
          w_pc_nxt = w_rpc;
          if (r_en && !imem_ready) begin
            // imem cannot cancel: keep the old address until it answers
            w_state_nxt = ST_DROP;
          end else begin
            w_en_nxt   = 1'b1;
            w_addr_nxt = w_rpc[ADDR_W-1:0];
          end
        end else begin
          if (w_done) begin
            w_push   = 1'b1;
            w_pc_nxt = w_pc_inc;
          end
          w_cnt_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
          if (!r_en || w_done) begin
            // The new request reserves a slot, so it needs room after this edge
            w_en_nxt   = (w_cnt_nxt < CNT_W'(DEPTH));
            w_addr_nxt = w_en_nxt ? w_pc_nxt[ADDR_W-1:0] : r_addr;
          end
        end
      end
      ST_DROP: begin
        w_pop   = 1'b0;
        w_flush = redirect;
        if (redirect) w_pc_nxt = w_rpc;
        if (imem_ready) begin
          w_state_nxt = ST_REQ;
          w_en_nxt    = 1'b1;
          w_addr_nxt  = w_pc_nxt[ADDR_W-1:0];
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_en_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_en       <= 1'b0;
      r_addr     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_pc_nxt;
      r_en       <= w_en_nxt;
      r_addr     <= w_addr_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_valid (w_fifo_vld),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign imem_en   = r_en;
  assign imem_addr = r_addr;
  assign if_valid  = w_fifo_vld;
  assign if_pc     = w_head.pc;
  assign if_instr  = w_head.instr;
  assign if_err    = w_head.err;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural imem answers requests, the
// expected instruction stream is queued per fetch segment and checked on pops.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_data_out = '0;
  logic        imem_ready = 1'b0;
  logic        imem_err = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_err;
  logic        id_ready = 1'b0;

  int   n_chk = 0;
  int   n_fail = 0;
  int   n_pops = 0;
  exp_t q[$];

  int          lat = 1;
  bit          rand_lat = 1'b0;
  bit          stray = 1'b0;
  int          cnt = 0;
  int          cur_lat = 1;
  logic        prev_rdy = 1'b0;
  logic [15:0] held = '0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_en(imem_en),
    .imem_data_out(imem_data_out), .imem_ready(imem_ready), .imem_err(imem_err),
    .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_err(if_err), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a ^ 16'h5A3C};
  endfunction

  function automatic logic mem_err(input logic [15:0] a);
    return (a[6:0] == 7'h0C);
  endfunction

  function automatic exp_t mk(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc[15:0]);
    e.err   = mem_err(pc[15:0]);
    return e;
  endfunction

  // A new fetch segment: decode must see start, start+4, ... from now on
  task automatic seg(input logic [31:0] start);
    q.delete();
    for (int i = 0; i < 64; i++) q.push_back(mk(start + 32'(4 * i)));
  endtask

  // Behavioural imem: per-request latency counted from the first cycle the request is visible
  initial forever begin
    @(negedge clk); #1;
    if (stray) begin
      imem_ready = 1'b1; imem_data_out = 32'hDEAD_BEEF; imem_err = 1'b1;
      prev_rdy = 1'b1; cnt = 0;
    end else if (!rst || !imem_en) begin
      imem_ready = 1'b0; imem_data_out = '0; imem_err = 1'b0;
      prev_rdy = 1'b0; cnt = 0;
    end else begin
      if (prev_rdy) cnt = 0;
      cnt++;
      if (cnt == 1) begin
        held    = imem_addr;
        cur_lat = rand_lat ? int'($urandom_range(1, 4)) : lat;
      end else begin
        chk("imem_addr_hold", imem_addr, held);
      end
      if (cnt >= cur_lat) begin
        imem_ready = 1'b1; imem_data_out = mem_word(imem_addr); imem_err = mem_err(imem_addr);
      end else begin
        imem_ready = 1'b0; imem_data_out = '0; imem_err = 1'b0;
      end
      prev_rdy = imem_ready;
    end
  end

  // Monitor: every accepted handshake is checked against the queued expectation
  initial forever begin
    exp_t e;
    @(negedge clk); #4;
    if (rst && if_valid && id_ready && !redirect) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL scoreboard: pop of pc %0h with no expected entry", if_pc);
      end else begin
        e = q.pop_front();
        n_pops++;
        chk("if_pc", if_pc, e.pc);
        chk("if_instr", if_instr, e.instr);
        chk("if_err", if_err, e.err);
        if (q.size() > 0 && q.size() < 8) q.push_back(mk(q[q.size()-1].pc + 32'd4));
      end
    end
  end

  task automatic do_reset(input bit with_stray);
    rst = 1'b0; redirect = 1'b0; id_ready = 1'b0; stray = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    chk("reset_outputs", {imem_en, imem_addr, if_valid, if_pc, if_instr, if_err}, '0);
    @(negedge clk);
    seg(32'h0);
    rst = 1'b1;
    stray = with_stray;
  endtask

  task automatic wait_addr(input logic [15:0] a, input int budget, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #3;
      if (imem_en && imem_addr == a) ok = 1'b1;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: no request at %0h within %0d cycles", nm, a, budget);
    end
  endtask

  task automatic wait_valid(input int budget, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #3;
      if (if_valid) ok = 1'b1;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: if_valid not seen within %0d cycles", nm, budget);
    end
  endtask

  initial begin
    bit ok;
    logic [31:0] rpc;

    // Back-to-back fetch with single-cycle imem
    lat = 1; rand_lat = 1'b0;
    do_reset(1'b0);
    id_ready = 1'b1;
    #3;
    chk("idle_no_request", imem_en, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #3;
      chk("b2b_addr", {imem_en, imem_addr}, {1'b1, 16'(4 * k)});
      if (k > 0) chk("if_pc_lag", {if_valid, if_pc}, {1'b1, 32'(4 * (k - 1))});
    end
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk); #3;
      if (if_valid && if_pc == 32'hC) ok = 1'b1;
    end
    chk("err_pc_seen", ok, 1'b1);
    chk("err_flag_c", if_err, 1'b1);
    @(negedge clk); #3;
    chk("after_err", {if_valid, if_pc, if_err}, {1'b1, 32'h10, 1'b0});

    // Backpressure fills the FIFO and stops fetch
    do_reset(1'b0);
    repeat (5) @(negedge clk);
    #3;
    chk("full_stops_fetch", imem_en, 1'b0);
    chk("full_head", {if_valid, if_pc}, {1'b1, 32'h0});
    id_ready = 1'b1;
    @(negedge clk); #3;
    chk("reopen_after_pop", {imem_en, imem_addr}, {1'b1, 16'h8});
    chk("head_after_pop", {if_valid, if_pc}, {1'b1, 32'h4});

    // Redirect while a slow request is open: old data must be dropped
    do_reset(1'b0);
    lat = 5; id_ready = 1'b1;
    wait_addr(16'h8, 40, "wait_req_8");
    redirect = 1'b1; redirect_pc = 32'h40; seg(32'h40);
    @(negedge clk);
    redirect = 1'b0;
    #3;
    chk("drop_holds_addr", {imem_en, imem_addr}, {1'b1, 16'h8});
    wait_addr(16'h40, 20, "wait_req_40");
    wait_valid(20, "wait_first_40");
    chk("first_pc_after_drop", if_pc, 32'h40);

    // Redirect coinciding with imem_ready and a pop; misaligned target
    lat = 1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); #3;
      if (i > 6 && imem_ready && if_valid) ok = 1'b1;
    end
    chk("ready_and_pop_setup", ok, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h202; seg(32'h200);
    @(negedge clk);
    redirect = 1'b0;
    #3;
    chk("flush_same_edge", if_valid, 1'b0);
    chk("redirect_next_req", {imem_en, imem_addr}, {1'b1, 16'h200});
    repeat (6) @(negedge clk);

    // Asynchronous reset in the middle of an open request
    lat = 5;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); #3;
      if (imem_en && !imem_ready) ok = 1'b1;
    end
    chk("midreq_setup", ok, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_reset", {imem_en, imem_addr, if_valid, if_pc, if_instr, if_err}, '0);
    lat = 1;
    do_reset(1'b1);
    @(negedge clk);
    stray = 1'b0;
    #3;
    chk("first_req_reset_pc", {imem_en, imem_addr}, {1'b1, 16'h0});
    wait_valid(10, "wait_after_stray");
    chk("stray_ignored", {if_pc, if_instr}, {32'h0, mem_word(16'h0)});

    // Randomized traffic: latency, backpressure and redirects
    rand_lat = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      id_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 29) == 0) begin
        rpc = 32'($urandom_range(0, 32'hFFFF));
        redirect = 1'b1; redirect_pc = rpc;
        seg({rpc[31:2], 2'b00});
      end else begin
        redirect = 1'b0;
      end
    end
    redirect = 1'b0;
    repeat (10) @(negedge clk);
    chk("progress", (n_pops > 300), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
